// File: rtl/unified_mem_responder.sv
// unified_mem_responder - shared single-port fetch/data memory with fixed multi-cycle latency
// Data port normally wins arbitration; a starve flag hands the next grant to a waiting fetch.
module unified_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 8,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0] mem [DEPTH_WORDS];

  logic [0:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              starve_q, starve_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              i_ack_q, i_ack_d, i_err_q, i_err_d;
  logic              d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [31:0]       i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  logic [IDX_W-1:0]  word_idx;
  logic [31:0]       rd_word, load_v, wlanes;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [3:0]        wmask;
  logic              fire, take_d, d_err_c, i_err_c, misalign, illegal, mem_we;

  assign word_idx = IDX_W'(32'(addr_q[ADDR_W-1:2]) % DEPTH_WORDS);
  assign rd_word  = mem[word_idx];
  assign byte_v   = rd_word[{addr_q[1:0], 3'b000} +: 8];
  assign half_v   = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
  assign fire     = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign i_err_c  = (addr_q[1:0] != 2'b00);
  assign d_err_c  = illegal || misalign || (we_q && f3_q[2]);
  assign mem_we   = fire && port_q && we_q && !d_err_c;

  // Decode size checks, load extension and store lane mask from the latched request
  always_comb begin
    misalign = 1'b0;
    illegal  = 1'b0;
    load_v   = 32'd0;
    wmask    = 4'b0000;
    wlanes   = wdata_q;
    case (f3_q)
      3'd0: begin
        load_v = {{24{byte_v[7]}}, byte_v};
        wmask  = 4'b0001 << addr_q[1:0];
        wlanes = {4{wdata_q[7:0]}};
      end
      3'd1: begin
        misalign = addr_q[0];
        load_v   = {{16{half_v[15]}}, half_v};
        wmask    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlanes   = {2{wdata_q[15:0]}};
      end
      3'd2: begin
        misalign = (addr_q[1:0] != 2'b00);
        load_v   = rd_word;
        wmask    = 4'b1111;
      end
      3'd4: load_v = {24'd0, byte_v};
      3'd5: begin
        misalign = addr_q[0];
        load_v   = {16'd0, half_v};
      end
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[word_idx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    port_d    = port_q;
    we_d      = we_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    take_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (d_req || i_req) begin
          take_d   = d_req && !(starve_q && i_req);
          port_d   = take_d;
          addr_d   = take_d ? d_addr : i_addr;
          we_d     = take_d && d_we;
          f3_d     = d_funct3;
          wdata_d  = d_wdata;
          cnt_d    = CNT_INIT;
          state_d  = S_WAIT;
          starve_d = take_d ? (starve_q || i_req) : 1'b0;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          if (port_q) begin
            d_ack_d   = 1'b1;
            d_err_d   = d_err_c;
            d_rdata_d = (d_err_c || we_q) ? 32'd0 : load_v;
          end else begin
            i_ack_d   = 1'b1;
            i_err_d   = i_err_c;
            i_rdata_d = i_err_c ? 32'd0 : rd_word;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      starve_q  <= 1'b0;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      i_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      i_rdata_q <= 32'd0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      port_q    <= port_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_ack_q   <= i_ack_d;
      i_err_q   <= i_err_d;
      i_rdata_q <= i_rdata_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign i_ack   = i_ack_q;
  assign i_err   = i_err_q;
  assign i_rdata = i_rdata_q;
  assign d_ack   = d_ack_q;
  assign d_err   = d_err_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
// tb/tb_unified_mem_responder.sv - scoreboard bench for unified_mem_responder (LATENCY=2 and LATENCY=1 instances)
module tb_unified_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_i_req, a_i_ack, a_i_err, a_d_req, a_d_we, a_d_ack, a_d_err;
  logic [7:0]  a_i_addr, a_d_addr;
  logic [2:0]  a_d_f3;
  logic [31:0] a_i_rdata, a_d_wdata, a_d_rdata;

  logic        b_i_req, b_i_ack, b_i_err, b_d_req, b_d_we, b_d_ack, b_d_err;
  logic [8:0]  b_i_addr, b_d_addr;
  logic [2:0]  b_d_f3;
  logic [31:0] b_i_rdata, b_d_wdata, b_d_rdata;

  unified_mem_responder #(.DEPTH_WORDS(64), .ADDR_W(8), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_ack(a_i_ack), .i_rdata(a_i_rdata), .i_err(a_i_err),
    .d_req(a_d_req), .d_we(a_d_we), .d_funct3(a_d_f3), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_ack(a_d_ack), .d_rdata(a_d_rdata), .d_err(a_d_err)
  );

  unified_mem_responder #(.DEPTH_WORDS(64), .ADDR_W(9), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata), .i_err(b_i_err),
    .d_req(b_d_req), .d_we(b_d_we), .d_funct3(b_d_f3), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata), .d_err(b_d_err)
  );

  typedef struct packed {
    logic        port;
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic port, input logic [31:0] rd, input logic err, input logic chk_rd);
    exp_t e;
    e.port = port; e.rd = rd; e.err = err; e.chk_rd = chk_rd;
    return e;
  endfunction

  always @(negedge clk) begin
    if (a_i_ack && a_d_ack) chk("a_one_ack", 1, 0);
    if (!a_d_ack && a_d_err) chk("a_d_err_noack", 1, 0);
    if (!a_i_ack && a_i_err) chk("a_i_err_noack", 1, 0);
    if (a_i_ack || a_d_ack) begin
      if (qa.size() == 0) chk("a_unexp_ack", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("a_port", {31'd0, a_d_ack}, {31'd0, ea.port});
        if (ea.port) begin
          chk("a_d_err", a_d_err, ea.err);
          if (ea.chk_rd) chk("a_d_rdata", a_d_rdata, ea.rd);
        end else begin
          chk("a_i_err", a_i_err, ea.err);
          chk("a_i_rdata", a_i_rdata, ea.rd);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_d_ack) begin
      if (qb.size() == 0) chk("b_unexp_ack", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("b_d_err", b_d_err, eb.err);
        if (eb.chk_rd) chk("b_d_rdata", b_d_rdata, eb.rd);
      end
    end
  end

  task automatic a_data(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    exp_t e;
    e = mk(1'b1, exp_rd, exp_err, !we || exp_err);
    qa.push_back(e);
    a_d_we = we; a_d_f3 = f3; a_d_addr = addr; a_d_wdata = wd; a_d_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_d_ack && n < 20);
    chk("a_d_lat", n, 3);
    a_d_req = 1'b0;
    @(negedge clk);
    chk("a_d_pulse", a_d_ack, 0);
    if (e.chk_rd) chk("a_d_hold", a_d_rdata, exp_rd);
  endtask

  task automatic a_fetch(input logic [7:0] addr, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    qa.push_back(mk(1'b0, exp_rd, exp_err, 1'b1));
    a_i_addr = addr; a_i_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_i_ack && n < 20);
    chk("a_i_lat", n, 3);
    a_i_req = 1'b0;
    @(negedge clk);
    chk("a_i_pulse", a_i_ack, 0);
  endtask

  task automatic b_data(input logic we, input logic [8:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd);
    int n;
    qb.push_back(mk(1'b1, exp_rd, 1'b0, !we));
    b_d_we = we; b_d_f3 = 3'd2; b_d_addr = addr; b_d_wdata = wd; b_d_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_d_ack && n < 20);
    chk("b_d_lat", n, 2);
    b_d_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    logic [8:0] b2b_addr [4];
    logic [31:0] b2b_exp [4];
    rst = 1'b1;
    a_i_req = 0; a_i_addr = 0; a_d_req = 0; a_d_we = 0; a_d_f3 = 0; a_d_addr = 0; a_d_wdata = 0;
    b_i_req = 0; b_i_addr = 0; b_d_req = 0; b_d_we = 0; b_d_f3 = 0; b_d_addr = 0; b_d_wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_a_d_ack", a_d_ack, 0);
    chk("rst_a_i_ack", a_i_ack, 0);
    chk("rst_a_d_rdata", a_d_rdata, 0);
    chk("rst_a_i_rdata", a_i_rdata, 0);
    chk("rst_a_errs", {a_i_err, a_d_err}, 0);
    chk("rst_b_d_ack", b_d_ack, 0);
    rst = 1'b0;
    @(negedge clk);

    a_data(1, 3'd2, 8'h10, 32'hDEADBEEF, 32'h0, 0);
    a_data(0, 3'd2, 8'h10, 32'h0, 32'hDEADBEEF, 0);
    a_data(1, 3'd0, 8'h13, 32'hAAAAAA7F, 32'h0, 0);
    a_data(0, 3'd0, 8'h13, 32'h0, 32'h0000007F, 0);
    a_data(0, 3'd4, 8'h11, 32'h0, 32'h000000BE, 0);
    a_data(0, 3'd1, 8'h12, 32'h0, 32'h00007FAD, 0);
    a_data(0, 3'd0, 8'h11, 32'h0, 32'hFFFFFFBE, 0);
    a_data(0, 3'd5, 8'h10, 32'h0, 32'h0000BEEF, 0);
    a_data(0, 3'd1, 8'h10, 32'h0, 32'hFFFFBEEF, 0);
    a_data(1, 3'd1, 8'h10, 32'hFFFF1234, 32'h0, 0);
    a_data(0, 3'd2, 8'h10, 32'h0, 32'h7FAD1234, 0);

    a_data(0, 3'd1, 8'h11, 32'h0, 32'h0, 1);
    a_data(1, 3'd2, 8'h12, 32'h55555555, 32'h0, 1);
    a_data(0, 3'd3, 8'h10, 32'h0, 32'h0, 1);
    a_data(1, 3'd4, 8'h10, 32'h00000055, 32'h0, 1);
    a_data(0, 3'd6, 8'h10, 32'h0, 32'h0, 1);
    a_data(0, 3'd2, 8'h10, 32'h0, 32'h7FAD1234, 0);

    a_fetch(8'h10, 32'h7FAD1234, 0);
    a_fetch(8'h12, 32'h0, 1);

    // Contention: data first, then the starved fetch despite d_req staying high
    a_data(1, 3'd2, 8'h14, 32'hCAFEF00D, 32'h0, 0);
    qa.push_back(mk(1'b1, 32'h7FAD1234, 1'b0, 1'b1));
    qa.push_back(mk(1'b0, 32'hCAFEF00D, 1'b0, 1'b1));
    qa.push_back(mk(1'b1, 32'hCAFEF00D, 1'b0, 1'b1));
    a_d_we = 0; a_d_f3 = 3'd2; a_d_addr = 8'h10; a_d_req = 1;
    a_i_addr = 8'h14; a_i_req = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_d_ack && n < 20);
    chk("c_d_first_lat", n, 3);
    a_d_addr = 8'h14;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_i_ack && n < 20);
    chk("c_i_next_lat", n, 3);
    a_i_req = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_d_ack && n < 20);
    chk("c_d_last_lat", n, 3);
    a_d_req = 0;
    @(negedge clk);

    // Reset in the last WAIT cycle of a store aborts it
    a_data(1, 3'd2, 8'h20, 32'h11111111, 32'h0, 0);
    a_d_we = 1; a_d_f3 = 3'd2; a_d_addr = 8'h20; a_d_wdata = 32'h12345678; a_d_req = 1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    a_d_req = 0;
    @(negedge clk);
    chk("mid_rst_d_ack", a_d_ack, 0);
    chk("mid_rst_d_rdata", a_d_rdata, 0);
    chk("mid_rst_i_rdata", a_i_rdata, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    a_data(0, 3'd2, 8'h20, 32'h0, 32'h11111111, 0);

    b_data(1, 9'h000, 32'hA5A50001, 32'h0);
    b_data(1, 9'h004, 32'h5A5A0002, 32'h0);
    b2b_addr[0] = 9'h100; b2b_exp[0] = 32'hA5A50001;
    b2b_addr[1] = 9'h004; b2b_exp[1] = 32'h5A5A0002;
    b2b_addr[2] = 9'h104; b2b_exp[2] = 32'h5A5A0002;
    b2b_addr[3] = 9'h000; b2b_exp[3] = 32'hA5A50001;
    for (int k = 0; k < 4; k++) qb.push_back(mk(1'b1, b2b_exp[k], 1'b0, 1'b1));
    b_d_we = 0; b_d_f3 = 3'd2; b_d_addr = b2b_addr[0]; b_d_req = 1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!b_d_ack && n < 20);
      chk("b_b2b_interval", n, 2);
      if (k < 3) b_d_addr = b2b_addr[k+1];
    end
    b_d_req = 0;

    repeat (4) @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
